// File: rtl/weight_mem_reader_if.sv
// Bundle of control, weight-memory read port and output stream signals for weight_mem_reader.
// The reader uses the master modport; memory model and sink use the slave modport.
interface weight_mem_reader_if;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] count;
  logic        busy;
  logic        done;
  logic [11:0] mem_addrb;
  logic        mem_enb;
  logic        mem_regceb;
  logic [31:0] mem_rdata;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;

  modport master (
    input  start, base_addr, count, mem_rdata, m_ready,
    output busy, done, mem_addrb, mem_enb, mem_regceb, m_data, m_valid
  );

  modport slave (
    output start, base_addr, count, mem_rdata, m_ready,
    input  busy, done, mem_addrb, mem_enb, mem_regceb, m_data, m_valid
  );
endinterface

// File: rtl/weight_mem_reader.sv
// Burst reader for a 2-cycle-latency weight memory feeding a small registered output FIFO.
// Issues are credit-limited so the FIFO never overflows, with a bubble on half-select changes.
module weight_mem_reader #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  weight_mem_reader_if.master bus
);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic              enb_q, enb_d;
  logic [11:0]       addrb_q, addrb_d;
  logic [11:0]       next_addr_q, next_addr_d;
  logic [12:0]       rem_q, rem_d;
  logic [CntW-1:0]   out_cnt_q, out_cnt_d, out_after_pop;
  logic              ret1_q, ret2_q;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   fifo_cnt_q;
  logic              pop, hazard, credit_ok;

  assign bus.m_valid    = (fifo_cnt_q != '0);
  assign bus.m_data     = fifo_q[rd_ptr_q];
  assign bus.mem_enb    = enb_q;
  assign bus.mem_addrb  = addrb_q;
  assign bus.mem_regceb = 1'b1;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);

  assign pop           = bus.m_valid & bus.m_ready;
  // Outstanding = issued (in flight or buffered) and not yet popped; one slot per FIFO entry.
  assign out_after_pop = out_cnt_q - CntW'(pop);
  assign credit_ok     = out_after_pop < CntW'(FIFO_DEPTH);
  // Memory picks the half one cycle after issue, so back-to-back issues must share addr[11].
  assign hazard        = enb_q && (next_addr_q[11] != addrb_q[11]);

  always_comb begin
    state_d     = state_q;
    enb_d       = 1'b0;
    addrb_d     = addrb_q;
    next_addr_d = next_addr_q;
    rem_d       = rem_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.count == 13'd0) begin
            state_d = StDone;
          end else begin
            enb_d       = 1'b1;
            addrb_d     = bus.base_addr;
            next_addr_d = bus.base_addr + 12'd1;
            rem_d       = bus.count - 13'd1;
            state_d     = StRun;
          end
        end
      end
      StRun: begin
        if (rem_q == 13'd0) begin
          state_d = StDrain;
        end else if (credit_ok && !hazard) begin
          enb_d       = 1'b1;
          addrb_d     = next_addr_q;
          next_addr_d = next_addr_q + 12'd1;
          rem_d       = rem_q - 13'd1;
        end
      end
      StDrain: begin
        if (pop && (out_cnt_q == CntW'(1))) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    out_cnt_d = out_after_pop + CntW'(enb_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      enb_q       <= 1'b0;
      addrb_q     <= '0;
      next_addr_q <= '0;
      rem_q       <= '0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      enb_q       <= enb_d;
      addrb_q     <= addrb_d;
      next_addr_q <= next_addr_d;
      rem_q       <= rem_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  // Return pipeline marks the cycle mem_rdata carries an issued word; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      ret1_q     <= 1'b0;
      ret2_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      ret1_q <= enb_q;
      ret2_q <= ret1_q;
      if (ret2_q) begin
        fifo_q[wr_ptr_q] <= bus.mem_rdata;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      fifo_cnt_q <= fifo_cnt_q + CntW'(ret2_q) - CntW'(pop);
    end
  end
endmodule

// File: tb/tb_weight_mem_reader.sv
// Bench for weight_mem_reader: vector table of bursts plus reset-abort sequence,
// with a 2-cycle memory model and address/data scoreboard queues.
module tb_weight_mem_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  weight_mem_reader_if bus ();

  weight_mem_reader #(.FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {8'hA5, a, ~a};
  endfunction

  // Memory model: low bits captured at issue, half bit taken from mem_addrb one cycle later.
  logic        p1_v = 1'b0;
  logic [10:0] p1_lo = '0;
  always @(posedge clk) begin
    p1_v          <= bus.mem_enb;
    p1_lo         <= bus.mem_addrb[10:0];
    bus.mem_rdata <= p1_v ? mem_word({bus.mem_addrb[11], p1_lo}) : 32'hDEAD_BEEF;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [11:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  int busy_cnt, done_cnt, done_cyc, first_valid, first_enb, enb_cnt, stall_enb, xfer_cnt;
  logic        prev_enb = 1'b0;
  logic        prev_busy = 1'b0;
  logic [11:0] prev_addrb = '0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.m_valid && first_valid < 0) first_valid = cyc;
      if (bus.mem_enb) begin
        enb_cnt++;
        if (!bus.m_ready) stall_enb++;
        if (first_enb < 0) first_enb = cyc;
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_issue: addr %0h issued, none expected", bus.mem_addrb);
        end else begin
          check("issue_addr", {20'd0, bus.mem_addrb}, {20'd0, exp_addr_q.pop_front()});
        end
        if (prev_enb) check("half_hazard", {31'd0, bus.mem_addrb[11]}, {31'd0, prev_addrb[11]});
      end else if (prev_busy && bus.busy) begin
        check("addrb_hold", {20'd0, bus.mem_addrb}, {20'd0, prev_addrb});
      end
      if (prev_hold) begin
        check("stall_valid", {31'd0, bus.m_valid}, 32'd1);
        check("stall_data", bus.m_data, prev_data);
      end
      if (bus.m_valid && bus.m_ready) begin
        xfer_cnt++;
        if (exp_data_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_word: got %0h, none expected", bus.m_data);
        end else begin
          check("out_data", bus.m_data, exp_data_q.pop_front());
        end
      end
      prev_hold = bus.m_valid && !bus.m_ready;
    end else begin
      prev_hold = 1'b0;
    end
    prev_enb   = bus.mem_enb;
    prev_busy  = bus.busy;
    prev_addrb = bus.mem_addrb;
    prev_data  = bus.m_data;
  end

  task automatic clear_stats();
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; first_valid = -1;
    first_enb = -1; enb_cnt = 0; stall_enb = 0; xfer_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"},   {31'd0, bus.done}, 32'd0);
    check({tag, "_enb"},    {31'd0, bus.mem_enb}, 32'd0);
    check({tag, "_addrb"},  {20'd0, bus.mem_addrb}, 32'd0);
    check({tag, "_valid"},  {31'd0, bus.m_valid}, 32'd0);
    check({tag, "_data"},   bus.m_data, 32'd0);
    check({tag, "_regceb"}, {31'd0, bus.mem_regceb}, 32'd1);
  endtask

  // poke: cycle offset after start at which a stray start is raised (0 = none).
  task automatic run_burst(input logic [11:0] b, input int n, input int stall, input int poke,
                           input int lat);
    int t;
    bit got;
    clear_stats();
    for (int k = 0; k < n; k++) begin
      logic [11:0] a;
      a = b + 12'(k);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem_word(a));
    end
    @(posedge clk); #1;
    t = cyc;
    bus.start     = 1'b1;
    bus.base_addr = b;
    bus.count     = 13'(n);
    bus.m_ready   = (stall == 0);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (done_cnt > 0) begin
        got = 1'b1;
      end else begin
        @(posedge clk); #1;
        bus.start     = (poke > 0) && (cyc == t + poke);
        bus.base_addr = 12'h555;
        bus.count     = 13'd7;
        if (cyc >= t + stall) bus.m_ready = 1'b1;
      end
    end
    bus.start = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done within 400 cycles (base %0h count %0d)", b, n);
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    if (lat >= 0) check("done_latency", done_cyc - t, lat);
    check("busy_cycles", busy_cnt, done_cyc - t);
    check("busy_after", {31'd0, bus.busy}, 32'd0);
    check("issue_count", enb_cnt, n);
    check("xfer_count", xfer_cnt, n);
    check("words_left", exp_data_q.size(), 0);
    if (n > 0) begin
      check("first_enb", first_enb - t, 1);
      check("first_valid", first_valid - t, 4);
    end else begin
      check("no_valid", first_valid, -1);
    end
    if (stall > 0) begin
      n_cmp++;
      if (stall_enb > 4 || stall_enb == 0) begin
        n_err++;
        $display("FAIL stall_issues: got %0d issues while stalled, required 1..4", stall_enb);
      end
    end
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  typedef struct {
    logic [11:0] base;
    int          cnt;
    int          stall;
    int          poke;
    int          done_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int t;
    vecs[0] = '{base: 12'h010, cnt: 4,  stall: 0,  poke: 3,  done_lat: 8};
    vecs[1] = '{base: 12'h7FE, cnt: 4,  stall: 0,  poke: 0,  done_lat: 9};
    vecs[2] = '{base: 12'hFFE, cnt: 3,  stall: 0,  poke: 0,  done_lat: 8};
    vecs[3] = '{base: 12'h000, cnt: 0,  stall: 0,  poke: 1,  done_lat: 1};
    vecs[4] = '{base: 12'h123, cnt: 8,  stall: 12, poke: 0,  done_lat: -1};
    vecs[5] = '{base: 12'h7FF, cnt: 1,  stall: 0,  poke: 0,  done_lat: 5};
    vecs[6] = '{base: 12'h3F0, cnt: 16, stall: 0,  poke: 10, done_lat: 20};
    vecs[7] = '{base: 12'h7FC, cnt: 10, stall: 0,  poke: 0,  done_lat: 15};

    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.count = '0;
    bus.m_ready = 1'b1;
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_burst(vecs[v].base, vecs[v].cnt, vecs[v].stall, vecs[v].poke, vecs[v].done_lat);
    end

    // Abort a 16-word burst with reset two cycles in.
    clear_stats();
    for (int k = 0; k < 16; k++) begin
      exp_addr_q.push_back(12'h100 + 12'(k));
      exp_data_q.push_back(mem_word(12'h100 + 12'(k)));
    end
    @(posedge clk); #1;
    t = cyc;
    bus.start = 1'b1;
    bus.base_addr = 12'h100;
    bus.count = 13'd16;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("abort");
    exp_addr_q.delete();
    exp_data_q.delete();
    clear_stats();
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_issues", enb_cnt, 0);
    check("abort_done", done_cnt, 0);
    check("abort_xfers", xfer_cnt, 0);
    check("abort_cycles", cyc - t, 11);

    run_burst(12'h0FF, 2, 0, 0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/weight_mem_reader.md
WEIGHT_MEM_READER -- requirements
Module: weight_mem_reader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets output buffer depth in 32-bit words; only 4 is required to be supported.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-005 base_addr  input  12  first weight word address; sampled with start.
REQ-006 count  input  13  number of words to read, 0..4096; sampled with start.
REQ-007 busy  output  1  high from the cycle after an accepted start through the done cycle inclusive.
REQ-008 done  output  1  one-cycle pulse when the burst completes.
REQ-009 mem_addrb  output  12  read address to weight memory.
REQ-010 mem_enb  output  1  read issue strobe to weight memory.
REQ-011 mem_regceb  output  1  tied high.
REQ-012 mem_rdata  input  32  weight memory registered read data.
REQ-013 m_data  output  32  output weight word.
REQ-014 m_valid  output  1  m_data valid.
REQ-015 m_ready  input  1  sink accepts; transfer when m_valid and m_ready are both high.

Function
REQ-016 Memory timing: a read issued with mem_enb=1 in cycle N returns on mem_rdata during cycle N+2; the block captures it into the FIFO at the end of N+2.
REQ-017 Memory selects the 32-bit half with mem_addrb[11] during cycle N+1; mem_addrb SHALL hold its value whenever mem_enb=0.
REQ-018 Half-select hazard: an issue whose addr[11] differs from the previous issue's addr[11] SHALL NOT occur in the cycle immediately after that previous issue; insert exactly one bubble cycle.
REQ-019 Issue address k of the burst is (base_addr + k) mod 4096, in increasing k order; wrap 0xFFF->0x000 is legal and also triggers the bubble of REQ-018.
REQ-020 Credit: an issue is allowed only when (reads in flight, issued but not yet captured) + FIFO occupancy < FIFO_DEPTH; FIFO SHALL never overflow.
REQ-021 With m_ready held high and no bubble, one read SHALL issue per cycle; sustained throughput is 1 word/cycle.
REQ-022 FIFO is registered (no fall-through); m_data/m_valid come from the FIFO head; m_data SHALL remain stable while m_valid=1 and m_ready=0.
REQ-023 Words appear on m_data in issue order with no loss or duplication.
REQ-024 FSM states: IDLE, RUN (issuing), DRAIN (all issued, waiting for in-flight and FIFO to empty), DONE.
REQ-025 IDLE->RUN on start with count>0; IDLE->DONE on start with count=0 (no reads issued).
REQ-026 RUN->DRAIN in the cycle after the last issue; DRAIN->DONE when the last word transfers on the output; DONE->IDLE after one cycle.
REQ-027 done=1 only in DONE; done asserts the cycle after the last output transfer.
REQ-028 start is ignored in any state other than IDLE.
REQ-029 Timing anchor: start high in cycle T -> first mem_enb in T+1 -> first m_valid in T+4.

Reset
REQ-030 On rst: state IDLE, busy=0, done=0, mem_enb=0, mem_addrb=0, m_valid=0, m_data=0, FIFO empty, in-flight count 0.
REQ-031 rst mid-burst SHALL abort it; in-flight returns are discarded; no done pulse; a start after reset release SHALL work normally.

Verification
REQ-032 base=0x010, count=4, m_ready=1, start at T -> mem_enb T+1..T+4 with addrb 0x010..0x013; m_valid T+4..T+7 with data in order; done at T+8.
REQ-033 base=0x7FE, count=4 -> issue addresses 0x7FE, 0x7FF, bubble, 0x800, 0x801; 4 words out correct, in order.
REQ-034 base=0xFFE, count=3 -> issues 0xFFE, 0xFFF, bubble, 0x000; 3 correct words, done once.
REQ-035 count=8, m_ready=0 for 12 cycles after start -> at most 4 mem_enb pulses before release; m_data stable while stalled; all 8 words delivered in order after release.
REQ-036 count=0 -> done at T+1, busy high for T+1 only, no mem_enb, no m_valid.
REQ-037 rst asserted 2 cycles into a count=16 burst -> all outputs at reset values next cycle, no further mem_enb; a new start with count=2 completes correctly.
